// File: rtl/aes_xact_pkg.sv
// Shared types and widths for the AES command responder.
package aes_xact_pkg;

  localparam int KEY_W = 256;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    OP_KEY,
    OP_ENC,
    OP_DEC,
    OP_ILL
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY_LOAD,
    KEY_WAIT,
    CRYPT_START,
    CRYPT_WAIT,
    RESPOND
  } state_t;

endpackage

// File: rtl/aes_xact_timer.sv
// Wait-state cycle counter; expired is high on the last permitted wait cycle.
module aes_xact_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT) + 1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/aes_cmd_responder.sv
// Sequences host key/encrypt/decrypt commands onto the AES core control ports
// and returns exactly one response per accepted command.
module aes_cmd_responder
  import aes_xact_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetH,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [KEY_W-1:0]   cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_op,
  output logic               rsp_err,
  output logic [BLK_W-1:0]   rsp_data,
  output logic [KEY_W-1:0]   core_key,
  output logic               core_key_load,
  input  logic               core_key_done,
  output logic               core_start,
  output logic               core_decrypt,
  output logic [BLK_W-1:0]   core_data,
  input  logic               core_done,
  input  logic [BLK_W-1:0]   core_result,
  output logic [CNT_W-1:0]   txn_count
);

  state_t state, state_nxt;
  op_t    op_q;
  op_t    op_in;
  logic   key_valid;
  logic   accept;
  logic   tmr_clr, tmr_en, expired;
  logic   err_set, kv_set, kv_clr, res_load;

  assign op_in = op_t'(cmd_op);

  aes_xact_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (resetH),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (resetH) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    core_key_load = 1'b0;
    core_start    = 1'b0;
    rsp_valid     = 1'b0;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;
    err_set       = 1'b0;
    kv_set        = 1'b0;
    kv_clr        = 1'b0;
    res_load      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op_in)
            OP_KEY: state_nxt = KEY_LOAD;
            OP_ENC, OP_DEC: begin
              if (key_valid) begin
                state_nxt = CRYPT_START;
              end else begin
                state_nxt = RESPOND;
                err_set   = 1'b1;
              end
            end
            default: begin
              state_nxt = RESPOND;
              err_set   = 1'b1;
            end
          endcase
        end
      end
      KEY_LOAD: begin
        core_key_load = 1'b1;
        kv_clr        = 1'b1;
        tmr_clr       = 1'b1;
        state_nxt     = KEY_WAIT;
      end
      KEY_WAIT: begin
        tmr_en = 1'b1;
        // A done arriving on the expiry cycle still counts as success.
        if (core_key_done) begin
          kv_set    = 1'b1;
          state_nxt = RESPOND;
        end else if (expired) begin
          err_set   = 1'b1;
          state_nxt = RESPOND;
        end
      end
      CRYPT_START: begin
        core_start = 1'b1;
        tmr_clr    = 1'b1;
        state_nxt  = CRYPT_WAIT;
      end
      CRYPT_WAIT: begin
        tmr_en = 1'b1;
        if (core_done) begin
          res_load  = 1'b1;
          state_nxt = RESPOND;
        end else if (expired) begin
          err_set   = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset abandons the command and swallows any pulse due this cycle.
    if (resetH) begin
      cmd_ready     = 1'b0;
      core_key_load = 1'b0;
      core_start    = 1'b0;
      rsp_valid     = 1'b0;
    end
  end

  assign accept       = cmd_valid && cmd_ready;
  assign core_decrypt = core_start && (op_q == OP_DEC);
  assign rsp_op       = op_q;

  always_ff @(posedge clk) begin
    if (resetH) begin
      op_q      <= OP_KEY;
      key_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      core_key  <= '0;
      core_data <= '0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        op_q     <= op_in;
        rsp_err  <= 1'b0;
        rsp_data <= '0;
        if (op_in == OP_KEY) begin
          core_key <= cmd_data;
        end else if (op_in != OP_ILL) begin
          core_data <= cmd_data[BLK_W-1:0];
        end
      end
      if (err_set) begin
        rsp_err <= 1'b1;
      end
      if (kv_clr) begin
        key_valid <= 1'b0;
      end
      if (kv_set) begin
        key_valid <= 1'b1;
      end
      if (res_load) begin
        rsp_data <= core_result;
      end
      if (rsp_valid && rsp_ready) begin
        txn_count <= txn_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_cmd_responder.sv
// Directed bench for aes_cmd_responder: stub AES core, transaction-level
// response model and a per-cycle compare process.
module tb_aes_cmd_responder;

  localparam int TIMEOUT  = 64;
  localparam int TB_CNT_W = 8;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic                clk;
  logic                resetH;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [255:0]        cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_op;
  logic                rsp_err;
  logic [127:0]        rsp_data;
  logic [255:0]        core_key;
  logic                core_key_load;
  logic                core_key_done;
  logic                core_start;
  logic                core_decrypt;
  logic [127:0]        core_data;
  logic                core_done;
  logic [127:0]        core_result;
  logic [TB_CNT_W-1:0] txn_count;

  aes_cmd_responder #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .resetH        (resetH),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_op        (rsp_op),
    .rsp_err       (rsp_err),
    .rsp_data      (rsp_data),
    .core_key      (core_key),
    .core_key_load (core_key_load),
    .core_key_done (core_key_done),
    .core_start    (core_start),
    .core_decrypt  (core_decrypt),
    .core_data     (core_data),
    .core_done     (core_done),
    .core_result   (core_result),
    .txn_count     (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stub core: done arrives a configurable number of wait cycles after the start pulse.
  int key_delay   = 14;
  int crypt_delay = 5;

  function automatic logic [127:0] stub_fn(input logic dec, input logic [127:0] blk);
    if (!dec) return (blk == PT) ? CT : ~blk;
    return (blk == CT) ? PT : ~blk;
  endfunction

  initial begin
    bit           c_seen, k_seen, c_arm, k_arm, s_dec;
    int           c_cnt, k_cnt;
    logic [127:0] s_data;
    c_seen = 0; k_seen = 0; c_arm = 0; k_arm = 0; c_cnt = 0; k_cnt = 0;
    s_dec = 0; s_data = '0;
    core_done = 1'b0; core_key_done = 1'b0; core_result = '0;
    forever begin
      @(negedge clk);
      if (resetH) begin
        c_seen = 0; k_seen = 0; c_arm = 0; k_arm = 0;
      end else begin
        if (core_start) begin
          c_seen = 1; s_data = core_data; s_dec = core_decrypt;
        end
        if (core_key_load) k_seen = 1;
      end
      @(posedge clk);
      #1;
      core_done = 1'b0; core_key_done = 1'b0; core_result = '0;
      if (c_seen) begin c_arm = 1; c_cnt = 0; c_seen = 0; end
      if (k_seen) begin k_arm = 1; k_cnt = 0; k_seen = 0; end
      if (c_arm) begin
        if (c_cnt == crypt_delay) begin
          core_done = 1'b1; core_result = stub_fn(s_dec, s_data); c_arm = 0;
        end
        c_cnt++;
      end
      if (k_arm) begin
        if (k_cnt == key_delay) begin
          core_key_done = 1'b1; k_arm = 0;
        end
        k_cnt++;
      end
    end
  end

  // Transaction model: what each command must answer and how long it takes.
  typedef struct {
    logic [1:0]   op;
    logic         err;
    logic [127:0] data;
  } exp_t;

  exp_t                expq[$];
  bit                  m_kv   = 0;
  logic [TB_CNT_W-1:0] mcount = '0;
  int                  n_start    = 0;
  int                  last_start = -1;

  function automatic void model(input logic [1:0] op, input logic [255:0] d,
                                output exp_t e, output int lat, output bit st);
    bit ok;
    e.op = op; e.err = 1'b1; e.data = '0; lat = 1; st = 0;
    if (op == 2'd0) begin
      ok    = (key_delay >= 0) && (key_delay < TIMEOUT);
      e.err = !ok;
      lat   = 3 + (ok ? key_delay : TIMEOUT - 1);
      m_kv  = ok;
    end else if (op != 2'd3 && m_kv) begin
      st    = 1;
      ok    = (crypt_delay >= 0) && (crypt_delay < TIMEOUT);
      e.err = !ok;
      lat   = 3 + (ok ? crypt_delay : TIMEOUT - 1);
      if (ok) e.data = (op == 2'd1) ? ((d[127:0] == PT) ? CT : ~d[127:0])
                                    : ((d[127:0] == CT) ? PT : ~d[127:0]);
    end
  endfunction

  function automatic void model_reset();
    expq.delete();
    m_kv   = 0;
    mcount = '0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (resetH) begin
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_key_load", core_key_load, 0);
    end else begin
      chk("txn_count", txn_count, mcount);
      if (core_start) begin
        n_start++;
        last_start = cyc;
      end
      if (cmd_ready && rsp_valid) chk("ready_during_rsp", cmd_ready, 0);
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          chk("rsp_op", rsp_op, expq[0].op);
          chk("rsp_err", rsp_err, expq[0].err);
          chk("rsp_data", rsp_data, expq[0].data);
          if (rsp_ready) begin
            void'(expq.pop_front());
            mcount = mcount + 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [255:0] d, input int hold,
                      output int lat, output logic err_o, output logic [127:0] data_o);
    exp_t e;
    int   exp_lat, acc, s0, n;
    bit   st, ok;
    lat = -1; err_o = 1'bx; data_o = 'x;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; rsp_ready = (hold == 0);
    n = 0; ok = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      n++;
    end
    if (!ok) begin
      chk("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    s0  = n_start;
    model(op, d, e, exp_lat, st);
    expq.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0; ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
      else n++;
    end
    if (!ok) begin
      chk("rsp_timeout", rsp_valid, 1);
      rsp_ready = 1'b1;
      return;
    end
    lat = cyc - acc; err_o = rsp_err; data_o = rsp_data;
    chk("latency", lat, exp_lat);
    chk("start_pulses", n_start - s0, st);
    if (st) chk("start_cycle", last_start, acc + 1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic         err;
    logic [127:0] dat;
    resetH = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetH = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_txn_count", txn_count, 0);
    chk("reset_core_key", core_key, 0);
    chk("reset_core_data", core_data, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_err", rsp_err, 0);

    send(2'd1, {128'd0, PT}, 0, lat, err, dat);
    chk("enc_nokey_lat", lat, 1);
    chk("enc_nokey_err", err, 1);
    chk("enc_nokey_data", dat, 0);

    send(2'd0, KEY, 0, lat, err, dat);
    chk("key_err", err, 0);
    chk("key_lat", lat, 17);
    chk("core_key", core_key, KEY);

    send(2'd1, {128'd0, PT}, 0, lat, err, dat);
    chk("enc_data", dat, CT);
    chk("enc_lat", lat, 8);
    send(2'd2, {128'd0, CT}, 0, lat, err, dat);
    chk("dec_data", dat, PT);

    crypt_delay = -1;
    send(2'd1, {128'd0, PT}, 0, lat, err, dat);
    chk("timeout_err", err, 1);
    chk("timeout_lat", lat, 66);
    chk("timeout_data", dat, 0);
    crypt_delay = 63;
    send(2'd1, {128'd0, PT}, 0, lat, err, dat);
    chk("last_cycle_done_err", err, 0);
    chk("last_cycle_done_data", dat, CT);

    crypt_delay = 2;
    send(2'd2, {128'd0, CT}, 10, lat, err, dat);
    chk("hold_dec_data", dat, PT);

    key_delay = -1;
    send(2'd0, KEY, 0, lat, err, dat);
    chk("key_timeout_err", err, 1);
    send(2'd1, {128'd0, PT}, 0, lat, err, dat);
    chk("enc_after_key_fail", err, 1);
    key_delay = 0;
    send(2'd0, KEY, 0, lat, err, dat);
    chk("key_fast_lat", lat, 3);

    // Reset landing on the start-pulse cycle.
    @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = {128'd0, PT};
    @(negedge clk);
    chk("accept_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0; resetH = 1'b1;
    @(negedge clk);
    chk("start_suppressed", core_start, 0);
    @(posedge clk);
    model_reset();
    #1 resetH = 1'b0;

    send(2'd0, KEY, 0, lat, err, dat);
    crypt_delay = -1;
    // Reset while the core is being waited on.
    @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = {128'd0, PT};
    @(negedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 resetH = 1'b1;
    @(posedge clk);
    model_reset();
    #1 resetH = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("post_reset_txn", txn_count, 0);
    crypt_delay = 5;
    send(2'd1, {128'd0, PT}, 0, lat, err, dat);
    chk("post_reset_nokey", err, 1);
    send(2'd3, '0, 0, lat, err, dat);
    chk("illegal_err", err, 1);
    chk("illegal_lat", lat, 1);

    for (int i = 0; i < (1 << TB_CNT_W) - 2; i++) begin
      send(2'd3, 256'(i), 0, lat, err, dat);
    end
    chk("txn_wrap", txn_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
